// File: rtl/bus_rr_arbiter_pkg.sv
// bus_pkg: shared types and limits for the az bus round-robin arbiter.
//   bus_arb_state_t  - arbiter FSM encoding (IDLE, GRANT, BUSY, RELEASE)
//   BUS_MAX_MASTERS  - largest supported master count
package bus_pkg;

  localparam int unsigned BUS_MAX_MASTERS = 8;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    GRANT   = 2'd1,
    BUSY    = 2'd2,
    RELEASE = 2'd3
  } bus_arb_state_t;

endpackage

// File: rtl/bus_rr_arbiter_pick.sv
// bus_rr_pick: combinational round-robin selector.
//   req_i    - active-high request vector
//   ptr_i    - index with highest priority this cycle
//   valid_o  - any request present
//   idx_o    - first requesting index at or after ptr_i, wrapping to 0
module bus_rr_pick
  import bus_pkg::*;
#(
  parameter  int unsigned NUM_MASTERS = 4,
  localparam int unsigned IDX_W       = $clog2(NUM_MASTERS)
) (
  input  logic [NUM_MASTERS-1:0] req_i,
  input  logic [IDX_W-1:0]       ptr_i,
  output logic                   valid_o,
  output logic [IDX_W-1:0]       idx_o
);

  logic [IDX_W-1:0] cand;

  always_comb begin
    valid_o = 1'b0;
    idx_o   = '0;
    cand    = '0;
    for (int unsigned k = 0; k < NUM_MASTERS; k++) begin
      cand = IDX_W'((32'(ptr_i) + k) % NUM_MASTERS);
      if (!valid_o && req_i[cand]) begin
        valid_o = 1'b1;
        idx_o   = cand;
      end
    end
  end

endmodule

// File: rtl/bus_rr_arbiter.sv
// bus_rr_arbiter: round-robin bus-ownership controller for the shared az bus.
// One master owns the bus at a time; ownership spans whole transfers and every
// handover passes through a single all-grants-high RELEASE cycle.
// Optional watchdog: define BUS_RR_TIMEOUT_EN to force-release a BUSY bus after
// TIMEOUT_CYCLES cycles without m_rdy.
//   bus_clk      - bus clock
//   bus_rstn     - asynchronous active-low reset
//   m_reqn       - per-master request, active-low
//   s_asn        - address strobe from current owner, active-low
//   m_rdy        - slave ready, active-high
//   m_grntn      - per-master grant, active-low, registered, one-hot-low
//   bus_owner    - index of current/last owner
//   bus_idle     - FSM is in IDLE
//   err_timeout  - one-cycle watchdog release pulse (0 without the watchdog)
module bus_rr_arbiter
  import bus_pkg::*;
#(
  parameter  int unsigned NUM_MASTERS    = 4,
  parameter  int unsigned TIMEOUT_CYCLES = 64,
  localparam int unsigned OWN_W          = $clog2(NUM_MASTERS)
) (
  input  logic                   bus_clk,
  input  logic                   bus_rstn,
  input  logic [NUM_MASTERS-1:0] m_reqn,
  input  logic                   s_asn,
  input  logic                   m_rdy,
  output logic [NUM_MASTERS-1:0] m_grntn,
  output logic [OWN_W-1:0]       bus_owner,
  output logic                   bus_idle,
  output logic                   err_timeout
);

  if (NUM_MASTERS < 2 || NUM_MASTERS > BUS_MAX_MASTERS || TIMEOUT_CYCLES < 2) begin : g_param_check
    $error("bus_rr_arbiter: parameter out of range");
  end

  bus_arb_state_t         state_q, state_d;
  logic [OWN_W-1:0]       owner_q, owner_d;
  logic [OWN_W-1:0]       ptr_q, ptr_d;
  logic [NUM_MASTERS-1:0] grntn_q, grntn_d;
  logic                   pick_valid;
  logic [OWN_W-1:0]       pick_idx;
  logic [OWN_W-1:0]       owner_inc;
  logic                   xfer_done;
  logic                   wd_hit;

  bus_rr_pick #(
    .NUM_MASTERS (NUM_MASTERS)
  ) u_pick (
    .req_i   (~m_reqn),
    .ptr_i   (ptr_q),
    .valid_o (pick_valid),
    .idx_o   (pick_idx)
  );

  assign xfer_done = !s_asn && m_rdy;
  assign owner_inc = (owner_q == OWN_W'(NUM_MASTERS - 1)) ? '0 : owner_q + 1'b1;

`ifdef BUS_RR_TIMEOUT_EN
  localparam int unsigned WD_W = $clog2(TIMEOUT_CYCLES);

  logic [WD_W-1:0] wd_cnt_q, wd_cnt_d;

  // Any non-BUSY cycle clears the count, so each BUSY entry starts from zero.
  always_comb begin
    wd_cnt_d = '0;
    if (state_q == BUSY) begin
      wd_cnt_d = m_rdy ? wd_cnt_q : wd_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge bus_clk or negedge bus_rstn) begin
    if (!bus_rstn) begin
      wd_cnt_q <= '0;
    end else begin
      wd_cnt_q <= wd_cnt_d;
    end
  end

  // Fires on the TIMEOUT_CYCLES-th stalled BUSY cycle; m_rdy that cycle suppresses it.
  assign wd_hit = (state_q == BUSY) && !m_rdy && (wd_cnt_q == WD_W'(TIMEOUT_CYCLES - 1));
`else
  assign wd_hit = 1'b0;
`endif

  // State register
  always_ff @(posedge bus_clk or negedge bus_rstn) begin
    if (!bus_rstn) begin
      state_q <= IDLE;
      owner_q <= '0;
      ptr_q   <= '0;
      grntn_q <= '1;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      ptr_q   <= ptr_d;
      grntn_q <= grntn_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    ptr_d   = ptr_q;
    unique case (state_q)
      IDLE: begin
        if (pick_valid) begin
          state_d = GRANT;
          owner_d = pick_idx;
        end
      end
      GRANT: begin
        if (!s_asn) begin
          state_d = BUSY;
        end else if (m_reqn[owner_q]) begin
          state_d = RELEASE;
        end
      end
      BUSY: begin
        if (xfer_done) begin
          state_d = m_reqn[owner_q] ? RELEASE : GRANT;
        end else if (wd_hit) begin
          state_d = RELEASE;
        end
      end
      RELEASE: begin
        // Pointer already advanced on entry, so this pick sees the new priority.
        if (pick_valid) begin
          state_d = GRANT;
          owner_d = pick_idx;
        end else begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    if ((state_q == GRANT || state_q == BUSY) && state_d == RELEASE) begin
      ptr_d = owner_inc;
    end
  end

  // Output logic: grant decoded from next state so it registers alongside it.
  always_comb begin
    grntn_d = '1;
    if (state_d == GRANT || state_d == BUSY) begin
      grntn_d[owner_d] = 1'b0;
    end
  end

  assign m_grntn     = grntn_q;
  assign bus_owner   = owner_q;
  assign bus_idle    = (state_q == IDLE);
  assign err_timeout = wd_hit;

endmodule

// File: tb/tb_bus_rr_arbiter.sv
// Directed self-checking bench for bus_rr_arbiter (4 masters, 8-cycle watchdog).
module tb_bus_rr_arbiter;

  logic       bus_clk = 1'b0;
  logic       bus_rstn;
  logic [3:0] m_reqn;
  logic       s_asn;
  logic       m_rdy;
  logic [3:0] m_grntn;
  logic [1:0] bus_owner;
  logic       bus_idle;
  logic       err_timeout;

  int tests = 0;
  int fails = 0;

  always #5 bus_clk = ~bus_clk;

  bus_rr_arbiter #(
    .NUM_MASTERS    (4),
    .TIMEOUT_CYCLES (8)
  ) dut (
    .bus_clk     (bus_clk),
    .bus_rstn    (bus_rstn),
    .m_reqn      (m_reqn),
    .s_asn       (s_asn),
    .m_rdy       (m_rdy),
    .m_grntn     (m_grntn),
    .bus_owner   (bus_owner),
    .bus_idle    (bus_idle),
    .err_timeout (err_timeout)
  );

  task automatic step;
    @(posedge bus_clk);
    #1;
  endtask

  task automatic do_reset;
    bus_rstn = 1'b0;
    m_reqn   = 4'b1111;
    s_asn    = 1'b1;
    m_rdy    = 1'b0;
    repeat (2) step;
    bus_rstn = 1'b1;
  endtask

  task automatic test_reset;
    do_reset;
    step;
    tests++;
    if (m_grntn !== 4'b1111) begin
      fails++; $display("FAIL reset_grant got=%b exp=1111", m_grntn);
    end
    tests++;
    if (bus_idle !== 1'b1) begin
      fails++; $display("FAIL reset_idle got=%b exp=1", bus_idle);
    end
    tests++;
    if (bus_owner !== 2'd0) begin
      fails++; $display("FAIL reset_owner got=%0d exp=0", bus_owner);
    end
    tests++;
    if (err_timeout !== 1'b0) begin
      fails++; $display("FAIL reset_err got=%b exp=0", err_timeout);
    end
  endtask

  task automatic test_idle_ignore;
    do_reset;
    s_asn = 1'b0;
    m_rdy = 1'b1;
    repeat (2) step;
    tests++;
    if (bus_idle !== 1'b1 || m_grntn !== 4'b1111) begin
      fails++; $display("FAIL idle_ignore idle=%b grant=%b exp idle=1 grant=1111", bus_idle, m_grntn);
    end
    s_asn = 1'b1;
    m_rdy = 1'b0;
  endtask

  task automatic test_rr_order;
    logic [1:0] e;
    logic [3:0] exp_g;
    do_reset;
    m_reqn = 4'b0000;
    step;
    for (int k = 0; k < 5; k++) begin
      e     = 2'(k % 4);
      exp_g = 4'b1111 ^ (4'b0001 << e);
      tests++;
      if (m_grntn !== exp_g || bus_owner !== e) begin
        fails++; $display("FAIL rr_grant k=%0d grant=%b owner=%0d exp grant=%b owner=%0d", k, m_grntn, bus_owner, exp_g, e);
      end
      s_asn = 1'b0;
      step;
      tests++;
      if (m_grntn !== exp_g) begin
        fails++; $display("FAIL rr_busy_hold k=%0d got=%b exp=%b", k, m_grntn, exp_g);
      end
      m_rdy  = 1'b1;
      m_reqn = 4'b0001 << e;
      step;
      tests++;
      if (m_grntn !== 4'b1111 || bus_idle !== 1'b0) begin
        fails++; $display("FAIL rr_dead_cycle k=%0d grant=%b idle=%b exp grant=1111 idle=0", k, m_grntn, bus_idle);
      end
      s_asn  = 1'b1;
      m_rdy  = 1'b0;
      m_reqn = 4'b0000;
      step;
    end
  endtask

  task automatic test_back_to_back;
    do_reset;
    m_reqn = 4'b1011;
    step;
    tests++;
    if (m_grntn !== 4'b1011 || bus_owner !== 2'd2) begin
      fails++; $display("FAIL b2b_first grant=%b owner=%0d exp grant=1011 owner=2", m_grntn, bus_owner);
    end
    for (int t = 0; t < 2; t++) begin
      s_asn = 1'b0;
      step;
      m_rdy = 1'b0;
      for (int c = 0; c < 2; c++) begin
        step;
        tests++;
        if (m_grntn !== 4'b1011) begin
          fails++; $display("FAIL b2b_busy t=%0d c=%0d got=%b exp=1011", t, c, m_grntn);
        end
      end
      m_rdy = 1'b1;
      step;
      m_rdy = 1'b0;
      tests++;
      if (m_grntn !== 4'b1011) begin
        fails++; $display("FAIL b2b_after_done t=%0d got=%b exp=1011", t, m_grntn);
      end
    end
    s_asn = 1'b1;
    step;
    tests++;
    if (m_grntn !== 4'b1011) begin
      fails++; $display("FAIL b2b_hold_grant got=%b exp=1011", m_grntn);
    end
  endtask

  // Master 1 drops its request mid-transfer; then master 3 releases with a wrap.
  task automatic test_drop_and_wrap;
    do_reset;
    m_reqn = 4'b1101;
    step;
    s_asn = 1'b0;
    step;
    m_reqn = 4'b1111;
    for (int c = 0; c < 2; c++) begin
      step;
      tests++;
      if (m_grntn !== 4'b1101) begin
        fails++; $display("FAIL drop_hold c=%0d got=%b exp=1101", c, m_grntn);
      end
    end
    // Masters 0 and 3 pending at release: new pointer 2 must select 3.
    m_rdy  = 1'b1;
    m_reqn = 4'b0110;
    step;
    tests++;
    if (m_grntn !== 4'b1111 || bus_owner !== 2'd1) begin
      fails++; $display("FAIL drop_release grant=%b owner=%0d exp grant=1111 owner=1", m_grntn, bus_owner);
    end
    s_asn = 1'b1;
    m_rdy = 1'b0;
    step;
    tests++;
    if (m_grntn !== 4'b0111 || bus_owner !== 2'd3) begin
      fails++; $display("FAIL drop_next grant=%b owner=%0d exp grant=0111 owner=3", m_grntn, bus_owner);
    end
    // Master 3 completes with masters 1 and 2 pending: pointer wraps to 0, picks 1.
    s_asn = 1'b0;
    step;
    m_rdy  = 1'b1;
    m_reqn = 4'b1001;
    step;
    tests++;
    if (m_grntn !== 4'b1111 || bus_owner !== 2'd3) begin
      fails++; $display("FAIL wrap_release grant=%b owner=%0d exp grant=1111 owner=3", m_grntn, bus_owner);
    end
    s_asn = 1'b1;
    m_rdy = 1'b0;
    step;
    tests++;
    if (m_grntn !== 4'b1101 || bus_owner !== 2'd1) begin
      fails++; $display("FAIL wrap_next grant=%b owner=%0d exp grant=1101 owner=1", m_grntn, bus_owner);
    end
  endtask

  task automatic test_grant_abandon;
    do_reset;
    m_reqn = 4'b0111;
    step;
    tests++;
    if (m_grntn !== 4'b0111 || bus_owner !== 2'd3) begin
      fails++; $display("FAIL abandon_grant grant=%b owner=%0d exp grant=0111 owner=3", m_grntn, bus_owner);
    end
    m_reqn = 4'b1111;
    step;
    tests++;
    if (m_grntn !== 4'b1111 || bus_idle !== 1'b0 || bus_owner !== 2'd3) begin
      fails++; $display("FAIL abandon_release grant=%b idle=%b owner=%0d exp 1111/0/3", m_grntn, bus_idle, bus_owner);
    end
    step;
    tests++;
    if (bus_idle !== 1'b1 || bus_owner !== 2'd3) begin
      fails++; $display("FAIL abandon_idle idle=%b owner=%0d exp idle=1 owner=3", bus_idle, bus_owner);
    end
  endtask

  task automatic test_async_reset;
    do_reset;
    m_reqn = 4'b1110;
    step;
    s_asn = 1'b0;
    step;
    tests++;
    if (m_grntn !== 4'b1110) begin
      fails++; $display("FAIL areset_pre got=%b exp=1110", m_grntn);
    end
    #2 bus_rstn = 1'b0;
    #1;
    tests++;
    if (m_grntn !== 4'b1111 || bus_idle !== 1'b1) begin
      fails++; $display("FAIL areset_release grant=%b idle=%b exp grant=1111 idle=1", m_grntn, bus_idle);
    end
    m_reqn = 4'b1111;
    s_asn  = 1'b1;
    #2 bus_rstn = 1'b1;
    step;
  endtask

`ifdef BUS_RR_TIMEOUT_EN
  task automatic test_timeout;
    do_reset;
    m_reqn = 4'b1110;
    step;
    s_asn = 1'b0;
    step;
    for (int c = 1; c < 8; c++) begin
      tests++;
      if (err_timeout !== 1'b0) begin
        fails++; $display("FAIL wd_early c=%0d got=%b exp=0", c, err_timeout);
      end
      step;
    end
    tests++;
    if (err_timeout !== 1'b1) begin
      fails++; $display("FAIL wd_pulse got=%b exp=1", err_timeout);
    end
    step;
    tests++;
    if (m_grntn !== 4'b1111 || err_timeout !== 1'b0) begin
      fails++; $display("FAIL wd_release grant=%b err=%b exp grant=1111 err=0", m_grntn, err_timeout);
    end
    s_asn = 1'b1;
    step;
    s_asn = 1'b0;
    step;
    repeat (7) step;
    m_rdy = 1'b1;
    tests++;
    if (err_timeout !== 1'b0) begin
      fails++; $display("FAIL wd_rdy_wins got=%b exp=0", err_timeout);
    end
    step;
    tests++;
    if (m_grntn !== 4'b1110 || err_timeout !== 1'b0) begin
      fails++; $display("FAIL wd_rdy_keep grant=%b err=%b exp grant=1110 err=0", m_grntn, err_timeout);
    end
    m_rdy = 1'b0;
    s_asn = 1'b1;
  endtask
`else
  task automatic test_no_timeout;
    do_reset;
    m_reqn = 4'b1110;
    step;
    s_asn = 1'b0;
    step;
    for (int c = 0; c < 12; c++) begin
      tests++;
      if (err_timeout !== 1'b0 || m_grntn !== 4'b1110) begin
        fails++; $display("FAIL nowd_busy c=%0d err=%b grant=%b exp err=0 grant=1110", c, err_timeout, m_grntn);
      end
      step;
    end
    s_asn = 1'b1;
  endtask
`endif

  initial begin
    test_reset;
    test_idle_ignore;
    test_rr_order;
    test_back_to_back;
    test_drop_and_wrap;
    test_grant_abandon;
    test_async_reset;
`ifdef BUS_RR_TIMEOUT_EN
    test_timeout;
`else
    test_no_timeout;
`endif
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
